// File: rtl/dmem_lsu.sv
// Load/store initiator: decodes a memory opcode, issues a single req/gnt/rvalid
// access to data memory and stalls the pipeline until it completes or times out.
module dmem_lsu #(
  parameter int AW      = 30,
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   Ins,
  input  logic [31:0]   Result,
  input  logic [31:0]   Rdata2,
  output logic          Stall,
  output logic [31:0]   Wdata,
  output logic          Misalign,
  output logic          BusErr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state_q;
  logic [5:0]      op_q;
  logic            ldOp_q;
  logic [1:0]      byteOff_q;
  logic [31:0]     loadData_q;
  logic [CW-1:0]   cnt_q;
  logic            misalign_q;
  logic            busErr_q;
  logic            memReq_q;
  logic            memWe_q;
  logic [AW-1:0]   memAddr_q;
  logic [3:0]      memBe_q;
  logic [31:0]     memWdata_q;

  logic [5:0]  op;
  logic        isLoad;
  logic        isStore;
  logic        isMem;
  logic        isAligned;
  logic [3:0]  beD;
  logic [31:0] wdataD;
  logic        unusedInsBits;

  assign unusedInsBits = ^Ins[25:0];

  always_comb begin
    op        = Ins[31:26];
    isLoad    = op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    isStore   = op inside {OP_SB, OP_SH, OP_SW};
    isMem     = isLoad | isStore;
    isAligned = 1'b1;
    beD       = 4'b0000;
    wdataD    = 32'h0;
    case (op)
      OP_LB, OP_LBU, OP_SB: begin
        beD    = 4'b0001 << Result[1:0];
        wdataD = {4{Rdata2[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        beD       = Result[1] ? 4'b1100 : 4'b0011;
        wdataD    = {2{Rdata2[15:0]}};
        isAligned = ~Result[0];
      end
      OP_LW, OP_SW: begin
        beD       = 4'b1111;
        wdataD    = Rdata2;
        isAligned = (Result[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  // Picks the addressed lane out of the returned word and sign/zero extends it.
  function automatic logic [31:0] extendLoad(input logic [5:0] opx, input logic [1:0] off,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (opx)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      op_q       <= 6'h0;
      ldOp_q     <= 1'b0;
      byteOff_q  <= 2'b00;
      loadData_q <= 32'h0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      busErr_q   <= 1'b0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memBe_q    <= 4'b0000;
      memWdata_q <= 32'h0;
    end else begin
      misalign_q <= 1'b0;
      busErr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (isMem) begin
            op_q      <= op;
            ldOp_q    <= isLoad;
            byteOff_q <= Result[1:0];
            if (!isAligned) begin
              misalign_q <= 1'b1;
              loadData_q <= 32'h0;
              state_q    <= DONE;
            end else begin
              memReq_q   <= 1'b1;
              memWe_q    <= isStore;
              memAddr_q  <= Result[AW+1:2];
              memBe_q    <= beD;
              memWdata_q <= isStore ? wdataD : 32'h0;
              cnt_q      <= '0;
              state_q    <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            memReq_q <= 1'b0;
            memWe_q  <= 1'b0;
            cnt_q    <= '0;
            if (!ldOp_q) begin
              state_q <= DONE;
            end else if (mem_rvalid) begin
              loadData_q <= extendLoad(op_q, byteOff_q, mem_rdata);
              state_q    <= DONE;
            end else begin
              state_q <= WAIT;
            end
          end else if (cnt_q == CNT_LAST) begin
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            busErr_q   <= 1'b1;
            loadData_q <= 32'h0;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            loadData_q <= extendLoad(op_q, byteOff_q, mem_rdata);
            state_q    <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            busErr_q   <= 1'b1;
            loadData_q <= 32'h0;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall is released in DONE so the pipeline advances exactly once per access.
  assign Stall = RST & (((state_q == IDLE) & isMem) | (state_q == REQ) | (state_q == WAIT));
  assign Wdata = ((state_q == DONE) && ldOp_q) ? loadData_q : Result;

  assign Misalign  = misalign_q;
  assign BusErr    = busErr_q;
  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_be    = memBe_q;
  assign mem_wdata = memWdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu: a per-access expectation model drives a
// scripted memory responder and checks stall length, bus fields and writeback.
module tb_dmem_lsu;
  localparam int AW      = 30;
  localparam int TIMEOUT = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic [31:0]   Ins;
  logic [31:0]   Result;
  logic [31:0]   Rdata2;
  logic          Stall;
  logic [31:0]   Wdata;
  logic          Misalign;
  logic          BusErr;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [5:0] memOps [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

  always #5 CLK = ~CLK;

  dmem_lsu #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
    .Stall(Stall), .Wdata(Wdata), .Misalign(Misalign), .BusErr(BusErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic int opSize(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2B:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit opIsLoad(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  function automatic bit opSigned(input logic [5:0] op);
    return op inside {6'h20, 6'h21};
  endfunction

  // One memory instruction: gntLat idle REQ cycles before gnt, rvLat cycles
  // from gnt to rvalid (0 = same cycle as gnt).
  task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [31:0] res,
                               input logic [31:0] rd2, input int gntLat, input int rvLat,
                               input logic [31:0] rdata);
    int size, expStall, expReq, stallN, reqN, waitN, unstable, cyc;
    bit load, mis, tout, granted;
    logic [31:0] expBe, expWd, expLoad, expW, mask, r;
    logic [31:0] capAddr, capBe, capWe, capWd;
    size = opSize(op);
    load = opIsLoad(op);
    mis  = (res % size) != 0;
    tout = !mis && ((gntLat >= TIMEOUT) || (load && rvLat > TIMEOUT));
    expBe = ((32'd1 << size) - 1) << (res % 4);
    if (size == 1)      expWd = {24'h0, rd2[7:0]} * 32'h01010101;
    else if (size == 2) expWd = {16'h0, rd2[15:0]} * 32'h00010001;
    else                expWd = rd2;
    if (load) expWd = 32'h0;
    mask    = (size == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * size)) - 1);
    expLoad = (rdata >> (8 * (res % 4))) & mask;
    if (opSigned(op) && expLoad >= ((mask >> 1) + 1)) expLoad = expLoad | ~mask;
    if (!load)           expW = res;
    else if (mis || tout) expW = 32'h0;
    else                 expW = expLoad;
    if (mis) begin
      expStall = 1; expReq = 0;
    end else if (gntLat >= TIMEOUT) begin
      expStall = 1 + TIMEOUT; expReq = TIMEOUT;
    end else if (!load) begin
      expStall = gntLat + 2; expReq = gntLat + 1;
    end else if (rvLat > TIMEOUT) begin
      expStall = gntLat + 2 + TIMEOUT; expReq = gntLat + 1;
    end else begin
      expStall = gntLat + 2 + rvLat; expReq = gntLat + 1;
    end

    @(negedge CLK);
    r = $urandom;
    Ins = {op, r[25:0]};
    Result = res;
    Rdata2 = rd2;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    checkOutput({tag, " prevPulseClear"}, {30'h0, Misalign, BusErr}, 32'h0);
    stallN = 0; reqN = 0; waitN = 0; unstable = 0; cyc = 0; granted = 0;
    capAddr = 0; capBe = 0; capWe = 0; capWd = 0;
    while (Stall === 1'b1 && cyc < 200) begin
      stallN++;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      if (mem_req === 1'b1) begin
        reqN++;
        if (reqN == 1) begin
          capAddr = {2'b00, mem_addr}; capBe = {28'h0, mem_be};
          capWe = {31'h0, mem_we};     capWd = mem_wdata;
        end else if ({2'b00, mem_addr} !== capAddr || {28'h0, mem_be} !== capBe ||
                     {31'h0, mem_we} !== capWe || mem_wdata !== capWd) begin
          unstable++;
        end
        if (reqN == gntLat + 1) begin
          mem_gnt = 1'b1;
          granted = 1;
          if (rvLat == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = rdata;
          end
        end else begin
          mem_rvalid = 1'($urandom_range(0, 1));
        end
      end else if (granted) begin
        waitN++;
        if (waitN == rvLat) begin
          mem_rvalid = 1'b1;
          mem_rdata = rdata;
        end
      end else begin
        mem_rvalid = 1'b1;
      end
      @(negedge CLK);
      #1;
      cyc++;
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    checkOutput({tag, " stallCycles"}, stallN, expStall);
    checkOutput({tag, " reqCycles"}, reqN, expReq);
    if (reqN > 0) begin
      checkOutput({tag, " addr"}, capAddr, res >> 2);
      checkOutput({tag, " be"}, capBe, expBe);
      checkOutput({tag, " we"}, capWe, {31'h0, !load});
      checkOutput({tag, " wdata"}, capWd, expWd);
      checkOutput({tag, " stable"}, unstable, 0);
    end
    checkOutput({tag, " Wdata"}, Wdata, expW);
    checkOutput({tag, " Misalign"}, {31'h0, Misalign}, {31'h0, mis});
    checkOutput({tag, " BusErr"}, {31'h0, BusErr}, {31'h0, tout});
  endtask

  task automatic nonMemStep(input string tag, input logic [31:0] res);
    logic [31:0] r;
    @(negedge CLK);
    r = $urandom;
    Ins = {6'h00, r[25:6], 6'h20};
    Result = res;
    #1;
    checkOutput({tag, " Stall"}, {31'h0, Stall}, 32'h0);
    checkOutput({tag, " Wdata"}, Wdata, res);
    checkOutput({tag, " req"}, {31'h0, mem_req}, 32'h0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST = 1'b0;
    Ins = {6'h23, 26'h0};
    Result = 32'h40;
    Rdata2 = 32'h0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(negedge CLK);
    #1;
    checkOutput("reset Stall", {31'h0, Stall}, 32'h0);
    checkOutput("reset req", {31'h0, mem_req}, 32'h0);
    checkOutput("reset we", {31'h0, mem_we}, 32'h0);
    checkOutput("reset be", {28'h0, mem_be}, 32'h0);
    checkOutput("reset addr", {2'b00, mem_addr}, 32'h0);
    checkOutput("reset wdata", mem_wdata, 32'h0);
    checkOutput("reset pulses", {30'h0, Misalign, BusErr}, 32'h0);
    RST = 1'b1;
    Ins = 32'h00000020;

    applyStimulus("lw40", 6'h23, 32'h40, 32'h0, 1, 3, 32'hDEADBEEF);
    applyStimulus("lb43", 6'h20, 32'h43, 32'h0, 0, 1, 32'h80FF00AA);
    applyStimulus("lbu43", 6'h24, 32'h43, 32'h0, 2, 2, 32'h80FF00AA);
    applyStimulus("sh12", 6'h29, 32'h12, 32'h1234ABCD, 0, 0, 32'h0);
    applyStimulus("lwMis", 6'h23, 32'h42, 32'h0, 0, 0, 32'h0);
    applyStimulus("swTimeout", 6'h2B, 32'h100, 32'h11223344, 1000, 0, 32'h0);
    applyStimulus("lhuZeroLat", 6'h25, 32'h22, 32'h0, 0, 0, 32'h9876FEDC);
    applyStimulus("sb", 6'h28, 32'h31, 32'h000000A5, 1, 0, 32'h0);
    nonMemStep("add", 32'h13572468);

    // Reset while waiting for read data, then a stray rvalid afterwards.
    @(negedge CLK);
    Ins = {6'h23, 26'h0};
    Result = 32'h80;
    #1;
    checkOutput("rst idleStall", {31'h0, Stall}, 32'h1);
    @(negedge CLK);
    #1;
    checkOutput("rst req", {31'h0, mem_req}, 32'h1);
    mem_gnt = 1'b1;
    @(negedge CLK);
    mem_gnt = 1'b0;
    #1;
    checkOutput("rst waitStall", {31'h0, Stall}, 32'h1);
    RST = 1'b0;
    Ins = 32'h00000020;
    Result = 32'h55AA1234;
    #1;
    checkOutput("rst forcedStall", {31'h0, Stall}, 32'h0);
    repeat (2) @(negedge CLK);
    #1;
    checkOutput("rst reqCleared", {31'h0, mem_req}, 32'h0);
    checkOutput("rst beCleared", {28'h0, mem_be}, 32'h0);
    RST = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    #1;
    checkOutput("rst lateRvalid Wdata", Wdata, 32'h55AA1234);
    @(negedge CLK);
    mem_rvalid = 1'b0;
    #1;
    checkOutput("rst after Wdata", Wdata, 32'h55AA1234);
    checkOutput("rst after Stall", {31'h0, Stall}, 32'h0);

    for (int i = 0; i < 40; i++) begin
      int k, sz, gl, rl;
      logic [5:0] op;
      logic [31:0] res;
      k = $urandom_range(0, 8);
      res = $urandom;
      if (k == 8) begin
        nonMemStep("rndAdd", res);
      end else begin
        op = memOps[k];
        sz = opSize(op);
        if ($urandom_range(0, 3) != 0) res = res & ~(32'(sz) - 1);
        gl = $urandom_range(0, 4);
        rl = $urandom_range(0, 4);
        applyStimulus($sformatf("rnd%0d", i), op, res, $urandom, gl, rl, $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
